// File: rtl/m_wb_pkg.sv
// Shared definitions for the midgetv Wishbone classic-cycle responder:
// FSM encodings, wait-state range check and a byte-lane merge helper.
package m_wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  localparam int WB_MAX_WAITSTATES = 15;

  function automatic logic ws_in_range(input int ws);
    return (ws >= 0) && (ws <= WB_MAX_WAITSTATES);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = sel[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/m_wb_responder_mem.sv
// Word-addressed 32-bit RAM with a registered, enabled read port and
// per-byte write enables, shaped so it maps onto block RAM.
module m_wb_responder_mem
  import m_wb_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic [3:0]        wr_be,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [31:0]       wr_data
);

  logic [31:0] mem_r [2**AWIDTH];
  logic [31:0] rd_data_r;

  // Read register only moves when a read is launched, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (wr_be[n]) begin
        mem_r[wr_addr][8*n +: 8] <= wr_data[8*n +: 8];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/m_wb_responder.sv
// Wishbone classic-cycle responder: local RAM answering with a one-cycle ACK
// after WAITSTATES wait cycles, supporting aborts and byte-lane writes.
module m_wb_responder
  import m_wb_pkg::*;
#(
  parameter int          AWIDTH                   = 8,
  parameter logic [31:0] BASEADR                  = 32'h6000_0000,
  parameter int          WAITSTATES               = 0,
  parameter bit          DAT_O_ZERO_WHEN_INACTIVE = 1'b1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        busy
);

  if (!ws_in_range(WAITSTATES)) begin : g_bad_waitstates
    $error("m_wb_responder: WAITSTATES must be within 0..15");
  end
  if (BASEADR[AWIDTH+1:0] != {(AWIDTH+2){1'b0}}) begin : g_bad_baseadr
    $error("m_wb_responder: BASEADR must be aligned to the RAM size");
  end

  localparam logic [3:0] WS_LOAD = 4'(WAITSTATES);

  wb_state_e         state_r, next_state_s;
  logic [3:0]        wcnt_r, next_wcnt_s;
  logic [AWIDTH-1:0] idx_r, req_idx_s, rd_addr_s;
  logic              we_r, ack_r, busy_r, dat_en_r;
  logic              hit_s, load_s, rd_en_s;
  logic [3:0]        wr_be_s;
  logic [31:0]       rd_data_s;
  logic              unused_adr_s;

  assign hit_s        = CYC_I & STB_I & (ADR_I[31:AWIDTH+2] == BASEADR[31:AWIDTH+2]);
  assign req_idx_s    = ADR_I[AWIDTH+1:2];
  assign unused_adr_s = ^ADR_I[1:0];

  // Next-state, wait counter and read-launch decode.
  always_comb begin
    next_state_s = state_r;
    next_wcnt_s  = wcnt_r;
    load_s       = 1'b0;
    rd_en_s      = 1'b0;
    case (state_r)
      WB_IDLE: begin
        if (hit_s && !ack_r) begin
          load_s      = 1'b1;
          next_wcnt_s = WS_LOAD;
          if (WAITSTATES == 0) begin
            next_state_s = WB_ACK;
            rd_en_s      = !WE_I;
          end else begin
            next_state_s = WB_WAIT;
          end
        end else begin
          next_state_s = WB_IDLE;
        end
      end
      WB_WAIT: begin
        if (!(CYC_I && STB_I)) begin
          next_state_s = WB_IDLE;
          next_wcnt_s  = 4'd0;
        end else if (wcnt_r == 4'd1) begin
          next_state_s = WB_ACK;
          next_wcnt_s  = wcnt_r - 4'd1;
          rd_en_s      = !we_r;
        end else begin
          next_state_s = WB_WAIT;
          next_wcnt_s  = wcnt_r - 4'd1;
        end
      end
      WB_ACK: begin
        next_state_s = WB_IDLE;
      end
      default: begin
        next_state_s = WB_IDLE;
        next_wcnt_s  = 4'd0;
      end
    endcase
  end

  // RAM port steering: the request address is only live while idle.
  always_comb begin
    if (state_r == WB_IDLE) begin
      rd_addr_s = req_idx_s;
    end else begin
      rd_addr_s = idx_r;
    end
    if ((state_r == WB_ACK) && we_r && CYC_I) begin
      wr_be_s = SEL_I;
    end else begin
      wr_be_s = 4'b0000;
    end
  end

  // Control state and registered bus outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r  <= WB_IDLE;
      wcnt_r   <= 4'd0;
      idx_r    <= {AWIDTH{1'b0}};
      we_r     <= 1'b0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      dat_en_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      wcnt_r  <= next_wcnt_s;
      if (load_s) begin
        idx_r <= req_idx_s;
        we_r  <= WE_I;
      end else begin
        idx_r <= idx_r;
        we_r  <= we_r;
      end
      ack_r  <= (next_state_s == WB_ACK);
      busy_r <= (next_state_s != WB_IDLE);
      // dat_en_r gates the RAM register so DAT_O reads 0 out of reset.
      if (rd_en_s) begin
        dat_en_r <= 1'b1;
      end else if (DAT_O_ZERO_WHEN_INACTIVE) begin
        dat_en_r <= 1'b0;
      end else begin
        dat_en_r <= dat_en_r;
      end
    end
  end

  m_wb_responder_mem #(
    .AWIDTH(AWIDTH)
  ) u_mem (
    .clk    (CLK_I),
    .rd_en  (rd_en_s),
    .rd_addr(rd_addr_s),
    .rd_data(rd_data_s),
    .wr_be  (wr_be_s),
    .wr_addr(idx_r),
    .wr_data(DAT_I)
  );

  assign ACK_O = ack_r;
  assign busy  = busy_r;
  assign DAT_O = dat_en_r ? rd_data_s : 32'h0000_0000;

endmodule

// File: tb/tb_m_wb_responder.sv
// Bench for m_wb_responder: three instances (0, 3 and 5 wait states) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_m_wb_responder;

  localparam int ND = 3;
  localparam int WS [ND] = '{0, 3, 5};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        cyc [ND], stb [ND], we [ND];
  logic [31:0] adr [ND], dati [ND];
  logic [3:0]  sel [ND];
  logic        ack [ND], busy [ND];
  logic [31:0] dato [ND];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    m_wb_responder #(
      .AWIDTH(8), .BASEADR(32'h6000_0000), .WAITSTATES(WS[g]),
      .DAT_O_ZERO_WHEN_INACTIVE(1'b1)
    ) dut (
      .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[g]), .STB_I(stb[g]), .WE_I(we[g]),
      .ADR_I(adr[g]), .DAT_I(dati[g]), .SEL_I(sel[g]),
      .ACK_O(ack[g]), .DAT_O(dato[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: actual=%h required=%h at %0t", name, g, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request is a pending transaction with an ACK deadline;
  // the RAM is a plain array updated when an ACKed write completes.
  bit   [31:0] mmem [ND][256];
  bit          m_pend [ND], m_we [ND], m_acknow [ND];
  logic [7:0]  m_idx [ND];
  int          m_due [ND];
  logic        exp_ack [ND], exp_busy [ND];
  logic [31:0] exp_dat [ND];
  int          cycle_n = 0;

  function automatic bit is_hit(input logic [31:0] a);
    return (a >> 10) == (32'h6000_0000 >> 10);
  endfunction

  task automatic model_step(input int g);
    bit fire = 1'b0;
    bit req  = cyc[g] && stb[g];
    if (m_acknow[g]) begin
      if (m_we[g] && cyc[g]) begin
        for (int n = 0; n < 4; n++) begin
          if (sel[g][n]) mmem[g][m_idx[g]][8*n +: 8] = dati[g][8*n +: 8];
        end
      end
      m_pend[g]   = 1'b0;
      m_acknow[g] = 1'b0;
    end else begin
      if (!m_pend[g] && req && is_hit(adr[g])) begin
        m_pend[g] = 1'b1;
        m_idx[g]  = adr[g][9:2];
        m_we[g]   = we[g];
        m_due[g]  = cycle_n + WS[g];
      end else if (m_pend[g] && !req) begin
        m_pend[g] = 1'b0;
      end
      if (m_pend[g] && (cycle_n == m_due[g])) fire = 1'b1;
    end
    m_acknow[g] = m_acknow[g] | fire;
    exp_ack[g]  = m_acknow[g];
    exp_busy[g] = m_pend[g];
    exp_dat[g]  = (fire && !m_we[g]) ? mmem[g][m_idx[g]] : 32'h0;
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      m_pend[g] = 1'b0; m_acknow[g] = 1'b0; m_we[g] = 1'b0; m_idx[g] = 8'd0; m_due[g] = 0;
      exp_ack[g] = 1'b0; exp_busy[g] = 1'b0; exp_dat[g] = 32'h0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int g = 0; g < ND; g++) begin
          m_pend[g] = 1'b0; m_acknow[g] = 1'b0;
          exp_ack[g] = 1'b0; exp_busy[g] = 1'b0; exp_dat[g] = 32'h0;
        end
      end else begin
        cycle_n++;
        for (int g = 0; g < ND; g++) model_step(g);
      end
    end
  end

  // Compare every instance against the model once per cycle.
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      chk("ack_o", g, 32'(ack[g]), 32'(exp_ack[g]));
      chk("busy", g, 32'(busy[g]), 32'(exp_busy[g]));
      chk("dat_o", g, dato[g], exp_dat[g]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int g);
    cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
    adr[g] = 32'h0; dati[g] = 32'h0; sel[g] = 4'h0;
  endtask

  task automatic xfer(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
    cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; dati[g] = d; sel[g] = s;
    lat = 0;
    rd  = 32'h0;
    while (lat < 40 && !ack[g]) begin
      tick();
      lat++;
    end
    if (!ack[g]) chk("ack_timeout", g, 32'(ack[g]), 32'd1);
    rd = dato[g];
    tick();
    idle_bus(g);
  endtask

  function automatic logic [31:0] pre(input int g, input int i);
    return 32'hA000_0000 | (32'(g) << 16) | 32'(i);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    int lat, acnt, bcnt;
    logic [5:0] apat, bpat;
    bit act [ND], pack [ND];
    int age [ND];

    for (int g = 0; g < ND; g++) idle_bus(g);
    rst = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < ND; g++) begin
      chk("reset_ack", g, 32'(ack[g]), 32'd0);
      chk("reset_busy", g, 32'(busy[g]), 32'd0);
      chk("reset_dat", g, dato[g], 32'h0);
    end
    rst = 1'b0;
    tick();

    for (int g = 0; g < ND; g++)
      for (int i = 0; i < 16; i++)
        xfer(g, 1'b1, 32'h6000_0000 + 32'(i) * 32'd4, pre(g, i), 4'hF, rd, lat);

    // zero wait states: write then read back
    xfer(0, 1'b1, 32'h6000_0010, 32'hDEAD_BEEF, 4'hF, rd, lat);
    chk("ws0_write_latency", 0, 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h6000_0010, 32'h0, 4'hF, rd, lat);
    chk("ws0_read_latency", 0, 32'(lat), 32'd1);
    chk("ws0_read_data", 0, rd, 32'hDEAD_BEEF);

    // three wait states: ACK and busy timing
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h6000_0008; sel[1] = 4'hF;
    apat = 6'd0; bpat = 6'd0; rd = 32'h0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j > 0 && apat[j-1]) idle_bus(1);
      apat[j] = ack[1];
      bpat[j] = busy[1];
      if (ack[1]) rd = dato[1];
    end
    idle_bus(1);
    chk("ws3_ack_pattern", 1, 32'(apat), 32'(6'b001000));
    chk("ws3_busy_pattern", 1, 32'(bpat), 32'(6'b001111));
    chk("ws3_read_data", 1, rd, 32'hA001_0002);
    tick();

    // byte-lane write
    xfer(0, 1'b1, 32'h6000_0020, 32'h1122_3344, 4'hF, rd, lat);
    xfer(0, 1'b1, 32'h6000_0020, 32'hAABB_CCDD, 4'b0101, rd, lat);
    xfer(0, 1'b0, 32'h6000_0020, 32'h0, 4'hF, rd, lat);
    chk("byte_lane_merge", 0, rd, 32'h11BB_33DD);

    // abort during WAIT
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h6000_0014;
    dati[2] = 32'h55AA_55AA; sel[2] = 4'hF;
    tick(); tick();
    chk("abort_busy_before", 2, 32'(busy[2]), 32'd1);
    cyc[2] = 1'b0;
    tick();
    chk("abort_busy_after", 2, 32'(busy[2]), 32'd0);
    acnt = 0;
    for (int j = 0; j < 10; j++) begin
      if (ack[2]) acnt++;
      tick();
    end
    idle_bus(2);
    chk("abort_no_ack", 2, 32'(acnt), 32'd0);
    xfer(2, 1'b0, 32'h6000_0014, 32'h0, 4'hF, rd, lat);
    chk("abort_mem_intact", 2, rd, 32'hA002_0005);
    chk("abort_next_latency", 2, 32'(lat), 32'd6);

    // miss
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h7000_0000; sel[0] = 4'hF;
    acnt = 0; bcnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (ack[0]) acnt++;
      if (busy[0]) bcnt++;
    end
    idle_bus(0);
    chk("miss_no_ack", 0, 32'(acnt), 32'd0);
    chk("miss_no_busy", 0, 32'(bcnt), 32'd0);

    // asynchronous reset: dut1 in ACK, dut2 in WAIT with a write pending
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h6000_0004; sel[1] = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h6000_0010;
    dati[2] = 32'h1234_5678; sel[2] = 4'hF;
    repeat (4) tick();
    chk("rst_pre_ack", 1, 32'(ack[1]), 32'd1);
    chk("rst_pre_busy", 2, 32'(busy[2]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ack", 1, 32'(ack[1]), 32'd0);
    chk("rst_async_busy", 1, 32'(busy[1]), 32'd0);
    chk("rst_async_dat", 1, dato[1], 32'h0);
    chk("rst_async_ack", 2, 32'(ack[2]), 32'd0);
    chk("rst_async_busy", 2, 32'(busy[2]), 32'd0);
    idle_bus(1);
    idle_bus(2);
    tick();
    rst = 1'b0;
    tick();
    xfer(2, 1'b0, 32'h6000_0010, 32'h0, 4'hF, rd, lat);
    chk("rst_write_discarded", 2, rd, 32'hA002_0004);
    xfer(0, 1'b0, 32'h6000_0010, 32'h0, 4'hF, rd, lat);
    chk("rst_mem_survives", 0, rd, 32'hDEAD_BEEF);

    // randomized traffic on all instances
    for (int g = 0; g < ND; g++) begin
      act[g] = 1'b0; pack[g] = 1'b0; age[g] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < ND; g++) begin
        if (act[g]) begin
          if (pack[g]) begin
            idle_bus(g);
            act[g] = 1'b0;
          end else if (!ack[g] && (age[g] > 25 || $urandom_range(0, 29) == 0)) begin
            case ($urandom_range(0, 2))
              0: cyc[g] = 1'b0;
              1: stb[g] = 1'b0;
              default: begin
                cyc[g] = 1'b0;
                stb[g] = 1'b0;
              end
            endcase
            act[g] = 1'b0;
          end else begin
            age[g]++;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          cyc[g]  = 1'b1;
          stb[g]  = 1'b1;
          we[g]   = 1'($urandom_range(0, 1));
          dati[g] = $urandom;
          sel[g]  = 4'($urandom);
          case ($urandom_range(0, 7))
            0: adr[g] = 32'h6000_0400 | 32'($urandom_range(0, 1023));
            1: adr[g] = 32'h5FFF_FFFC;
            default: adr[g] = 32'h6000_0000 + 32'($urandom_range(0, 15)) * 32'd4
                              + 32'($urandom_range(0, 3));
          endcase
          act[g] = 1'b1;
          age[g] = 0;
        end
        pack[g] = act[g] && ack[g];
      end
      tick();
    end
    for (int g = 0; g < ND; g++) idle_bus(g);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
